qk_seq_ctrl: RTL and testbench

- Hardware sequencer that replaces the bench-driven instruction stream for the multi-core Q·K attention fullchip.
- Accepts Q and K vectors from a host over a valid/ready stream and writes them into each core's qmem and kmem.
- Then issues the load, execute and ofifo-to-pmem drain phases on one per-core instruction bus per core.
- Generalised over core count, vector count, address width, inter-phase gap, and a latched sign/width mode.

---
 rtl/qk_seq_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_qk_seq_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qk_seq_ctrl.sv
// Q/K attention fullchip sequencer: streams Q and K vectors from the host into
// per-core memories, then issues the load, execute and drain phases on each core's bus.
module qk_seq_ctrl #(
  parameter int num_core = 2,
  parameter int bw       = 4,
  parameter int pr       = 8,
  parameter int col      = 8,
  parameter int addr_bw  = 4,
  parameter int gap      = 10
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [addr_bw:0]                     n_q,
  input  logic [1:0]                           mode_in,
  input  logic [pr*bw-1:0]                     in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [num_core*(9+2*addr_bw)-1:0]    inst,
  output logic [num_core*pr*bw-1:0]            mem_in,
  output logic                                 width_mode,
  output logic                                 sign_mode,
  output logic                                 busy,
  output logic                                 done,
  output logic [2:0]                           phase
);
  localparam int IW      = 9 + 2*addr_bw;
  localparam int LW      = pr*bw;
  localparam int F_PWR   = 0;
  localparam int F_KWR   = 2;
  localparam int F_KRD   = 3;
  localparam int F_QWR   = 4;
  localparam int F_QRD   = 5;
  localparam int F_LOAD  = 6;
  localparam int F_EXE   = 7;
  localparam int F_PADD  = 8;
  localparam int F_QKADD = 8 + addr_bw;
  localparam int F_OFR   = IW - 1;

  typedef enum logic [3:0] {
    S_IDLE, S_QWR, S_KWR, S_GAP1, S_LOAD, S_GAP2, S_EXEC, S_GAP3, S_DRAIN, S_DONE
  } state_t;

  state_t             state;
  logic [31:0]        cnt;
  logic [addr_bw:0]   nq;
  logic               nq_ok;
  logic               beat;
  logic [31:0]        nq_last;

  function automatic logic [addr_bw-1:0] addr_of(input logic [31:0] v);
    return v[addr_bw-1:0];
  endfunction

  assign in_ready = (state == S_QWR) || (state == S_KWR);
  assign beat     = in_valid && in_ready;
  assign nq_ok    = (n_q != '0) && (32'(n_q) <= (32'd1 << addr_bw));
  assign nq_last  = 32'(nq) - 32'd1;

  always_comb begin
    phase = 3'd0;
    case (state)
      S_QWR:                  phase = 3'd1;
      S_KWR:                  phase = 3'd2;
      S_GAP1, S_GAP2, S_GAP3: phase = 3'd3;
      S_LOAD:                 phase = 3'd4;
      S_EXEC:                 phase = 3'd5;
      S_DRAIN:                phase = 3'd6;
      S_DONE:                 phase = 3'd7;
      default:                phase = 3'd0;
    endcase
  end

  // Bus outputs are decoded from the pre-edge (state, cnt), so they trail state by one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      nq         <= '0;
      inst       <= '0;
      mem_in     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      width_mode <= 1'b0;
      sign_mode  <= 1'b0;
    end else begin
      inst <= '0;
      done <= 1'b0;
      busy <= (state != S_IDLE) && (state != S_DONE);
      case (state)
        S_IDLE: begin
          if (start && nq_ok) begin
            nq         <= n_q;
            width_mode <= mode_in[1];
            sign_mode  <= mode_in[0];
            cnt        <= '0;
            state      <= S_QWR;
          end
        end
        S_QWR: begin
          if (beat) begin
            for (int unsigned c = 0; c < num_core; c++) begin
              inst[c*IW + F_QWR]              <= 1'b1;
              inst[c*IW + F_QKADD +: addr_bw] <= addr_of(cnt);
              mem_in[c*LW +: LW]              <= in_data;
            end
            if (cnt == nq_last) begin
              cnt   <= '0;
              state <= S_KWR;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
        end
        S_KWR: begin
          if (beat) begin
            for (int unsigned c = 0; c < num_core; c++) begin
              if (cnt >= c*col && cnt < (c+1)*col) begin
                inst[c*IW + F_KWR]              <= 1'b1;
                inst[c*IW + F_QKADD +: addr_bw] <= addr_of(cnt - c*col);
                mem_in[c*LW +: LW]              <= in_data;
              end
            end
            if (cnt == 32'(num_core*col - 1)) begin
              cnt   <= '0;
              state <= S_GAP1;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
        end
        S_GAP1, S_GAP2, S_GAP3: begin
          if (cnt == 32'(gap - 1)) begin
            cnt   <= '0;
            state <= (state == S_GAP1) ? S_LOAD : (state == S_GAP2) ? S_EXEC : S_DRAIN;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_LOAD: begin
          // k=0 and k=col+1 bracket the kmem reads so the load pipeline fills and flushes.
          for (int unsigned c = 0; c < num_core; c++) begin
            inst[c*IW + F_LOAD] <= 1'b1;
            inst[c*IW + F_KRD]  <= (cnt >= 32'd1) && (cnt <= 32'(col));
            if (cnt >= 32'd2 && cnt <= 32'(col))
              inst[c*IW + F_QKADD +: addr_bw] <= addr_of(cnt - 32'd1);
          end
          if (cnt == 32'(col + 1)) begin
            cnt   <= '0;
            state <= S_GAP2;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_EXEC: begin
          for (int unsigned c = 0; c < num_core; c++) begin
            inst[c*IW + F_EXE]              <= 1'b1;
            inst[c*IW + F_QRD]              <= 1'b1;
            inst[c*IW + F_QKADD +: addr_bw] <= addr_of(cnt);
          end
          if (cnt == nq_last) begin
            cnt   <= '0;
            state <= S_GAP3;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_DRAIN: begin
          for (int unsigned c = 0; c < num_core; c++) begin
            inst[c*IW + F_OFR]             <= 1'b1;
            inst[c*IW + F_PWR]             <= 1'b1;
            inst[c*IW + F_PADD +: addr_bw] <= addr_of(cnt);
          end
          if (cnt == nq_last) begin
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qk_seq_ctrl.sv
// Self-checking bench for qk_seq_ctrl: table of jobs checked cycle by cycle against
// an expected-output queue, plus hand sequences for reset, illegal start and a 4-core build.
module tb_qk_seq_ctrl;
  localparam int NC  = 2;
  localparam int BW  = 4;
  localparam int PR  = 8;
  localparam int COL = 8;
  localparam int AB  = 4;
  localparam int GAP = 10;
  localparam int IW  = 9 + 2*AB;
  localparam int LW  = PR*BW;
  localparam int NC1 = 4;
  localparam int COL1 = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [AB:0]       n_q = '0;
  logic [1:0]        mode_in = '0;
  logic [LW-1:0]     in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NC*IW-1:0]  inst;
  logic [NC*LW-1:0]  mem_in;
  logic              width_mode, sign_mode, busy, done;
  logic [2:0]        phase;

  logic              start1 = 1'b0;
  logic [AB:0]       n_q1 = '0;
  logic [1:0]        mode1 = '0;
  logic [LW-1:0]     in_data1 = '0;
  logic              in_valid1 = 1'b0;
  logic              in_ready1;
  logic [NC1*IW-1:0] inst1;
  logic [NC1*LW-1:0] mem_in1;
  logic              width1, sign1, busy1, done1;
  logic [2:0]        phase1;

  qk_seq_ctrl #(.num_core(NC), .bw(BW), .pr(PR), .col(COL), .addr_bw(AB), .gap(GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .n_q(n_q), .mode_in(mode_in),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .mem_in(mem_in), .width_mode(width_mode), .sign_mode(sign_mode), .busy(busy),
    .done(done), .phase(phase));

  qk_seq_ctrl #(.num_core(NC1), .bw(BW), .pr(PR), .col(COL1), .addr_bw(AB), .gap(3)) dut4 (
    .clk(clk), .reset(reset), .start(start1), .n_q(n_q1), .mode_in(mode1),
    .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1), .inst(inst1),
    .mem_in(mem_in1), .width_mode(width1), .sign_mode(sign1), .busy(busy1),
    .done(done1), .phase(phase1));

  always #5 clk = ~clk;

  typedef struct {
    logic [NC*IW-1:0] inst;
    logic [NC*LW-1:0] mem;
    logic             busy;
    logic             done;
  } exp_t;

  typedef struct {
    int         nq;
    logic [1:0] mode;
    int         stall_at;
    int         stall_len;
    bit         kpulse;
    int         exp_done;
  } job_t;

  exp_t           sb[$];
  logic           sv_valid[$];
  logic [LW-1:0]  sv_data[$];
  logic [NC*LW-1:0] mm = '0;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
    end
  endtask

  function automatic logic [LW-1:0] dat(input int kind, input int i);
    logic [31:0] k = 32'(kind);
    logic [31:0] x = 32'(i);
    return (k * 32'h0100_0193 + (x + 32'd1) * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic logic [IW-1:0] fld(input int qk, input int pm, input logic ofr,
                                        input logic exe, input logic ld, input logic qrd,
                                        input logic qwr, input logic krd, input logic kwr,
                                        input logic pwr);
    logic [IW-1:0] f = '0;
    f[IW-1]     = ofr;
    f[8+AB +: AB] = qk[AB-1:0];
    f[8 +: AB]  = pm[AB-1:0];
    f[7] = exe; f[6] = ld; f[5] = qrd; f[4] = qwr;
    f[3] = krd; f[2] = kwr; f[1] = 1'b0; f[0] = pwr;
    return f;
  endfunction

  task automatic push(input logic [NC*IW-1:0] i, input logic b, input logic d,
                      input logic v, input logic [LW-1:0] x);
    sb.push_back('{i, mm, b, d});
    sv_valid.push_back(v);
    sv_data.push_back(x);
  endtask

  task automatic build(input job_t j);
    logic [NC*IW-1:0] iv;
    logic [LW-1:0] d;
    int jk = 0;
    for (int i = 0; i < j.nq; i++) begin
      if (i == j.stall_at)
        for (int s = 0; s < j.stall_len; s++) push('0, 1'b1, 1'b0, 1'b0, dat(3, s));
      d = dat(0, i);
      for (int c = 0; c < NC; c++) mm[c*LW +: LW] = d;
      push({NC{fld(i, 0, 0, 0, 0, 0, 1, 0, 0, 0)}}, 1'b1, 1'b0, 1'b1, d);
    end
    for (int b = 0; b < NC*COL; b++) begin
      d = dat(1, b);
      iv = '0;
      iv[(b/COL)*IW +: IW] = fld(b % COL, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      mm[(b/COL)*LW +: LW] = d;
      push(iv, 1'b1, 1'b0, 1'b1, d);
    end
    for (int g = 0; g < GAP; g++) push('0, 1'b1, 1'b0, 1'b1, dat(2, jk++));
    for (int k = 0; k < COL + 2; k++)
      push({NC{fld((k >= 2 && k <= COL) ? k - 1 : 0, 0, 0, 0, 1, 0, 0,
                   (k >= 1 && k <= COL), 0, 0)}}, 1'b1, 1'b0, 1'b1, dat(2, jk++));
    for (int g = 0; g < GAP; g++) push('0, 1'b1, 1'b0, 1'b1, dat(2, jk++));
    for (int k = 0; k < j.nq; k++)
      push({NC{fld(k, 0, 0, 1, 0, 1, 0, 0, 0, 0)}}, 1'b1, 1'b0, 1'b1, dat(2, jk++));
    for (int g = 0; g < GAP; g++) push('0, 1'b1, 1'b0, 1'b1, dat(2, jk++));
    for (int k = 0; k < j.nq; k++)
      push({NC{fld(0, k, 1, 0, 0, 0, 0, 0, 0, 1)}}, 1'b1, 1'b0, 1'b1, dat(2, jk++));
    push('0, 1'b0, 1'b1, 1'b1, dat(2, jk++));
  endtask

  task automatic run_job(input job_t j);
    exp_t e;
    int cyc = 0;
    int done_at = -1;
    build(j);
    @(negedge clk);
    start = 1'b1; n_q = (AB+1)'(j.nq); mode_in = j.mode; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("start_accept", 256'({in_ready, busy, phase}), 256'({1'b1, 1'b0, 3'd1}));
    while (sb.size() > 0) begin
      @(negedge clk);
      start    = j.kpulse && (cyc == j.nq + 2);
      mode_in  = ~j.mode;
      n_q      = 5'd8;
      in_valid = sv_valid.pop_front();
      in_data  = sv_data.pop_front();
      @(posedge clk); #1;
      cyc++;
      e = sb.pop_front();
      chk($sformatf("stream_c%0d", cyc), 256'({inst, mem_in, busy, done}),
          256'({e.inst, e.mem, e.busy, e.done}));
      if (done === 1'b1 && done_at < 0) done_at = cyc;
    end
    chk("done_cycle", 256'(done_at), 256'(j.exp_done));
    chk("mode_latched", 256'({width_mode, sign_mode}), 256'(j.mode));
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("idle_after", 256'({busy, done, phase, inst}), 256'(0));
    end
  endtask

  job_t jobs[5];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NC1*LW-1:0] mm1;
    logic [NC1*IW-1:0] iv1;
    logic [LW-1:0]     d;
    int w;
    jobs[0] = '{8,  2'b00, 99, 0, 1'b0, 81};
    jobs[1] = '{8,  2'b01, 3,  3, 1'b0, 84};
    jobs[2] = '{16, 2'b10, 99, 0, 1'b1, 105};
    jobs[3] = '{3,  2'b11, 1,  2, 1'b0, 68};
    jobs[4] = '{1,  2'b01, 99, 0, 1'b1, 60};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 256'({inst, mem_in, busy, done, width_mode, sign_mode, phase, in_ready}), 256'(0));
    @(negedge clk) reset = 1'b1;

    for (int t = 0; t < 5; t++) run_job(jobs[t]);

    // Illegal job sizes must leave the controller idle.
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      start = 1'b1; n_q = (t == 0) ? 5'd0 : 5'd17; in_valid = 1'b1; in_data = dat(4, t);
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        chk("bad_nq_idle", 256'({phase, in_ready, busy, done, inst, mem_in}),
            256'({3'd0, 1'b0, 1'b0, 1'b0, {(NC*IW){1'b0}}, mm}));
        @(negedge clk) start = 1'b0;
      end
    end

    // Reset in the middle of EXEC.
    @(negedge clk);
    start = 1'b1; n_q = 5'd4; mode_in = 2'b11; in_valid = 1'b1; in_data = dat(5, 0);
    @(negedge clk) start = 1'b0;
    w = 0;
    while (phase !== 3'd5 && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    chk("reach_exec", 256'(phase), 256'(5));
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("reset_in_exec", 256'({inst, mem_in, busy, done, phase, width_mode, sign_mode}), 256'(0));
    @(negedge clk) reset = 1'b1; in_valid = 1'b0;
    mm = '0;
    run_job('{1, 2'b00, 99, 0, 1'b0, 60});

    // Four-core build: each K beat lands on exactly one core.
    mm1 = '0;
    @(negedge clk);
    start1 = 1'b1; n_q1 = 5'd1; mode1 = 2'b00; in_valid1 = 1'b0;
    @(negedge clk);
    start1 = 1'b0; in_valid1 = 1'b1; in_data1 = dat(0, 0);
    @(posedge clk); #1;
    for (int c = 0; c < NC1; c++) mm1[c*LW +: LW] = dat(0, 0);
    chk("k4_qbeat", 256'({inst1, mem_in1}), 256'({{NC1{fld(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)}}, mm1}));
    for (int b = 0; b < NC1*COL1; b++) begin
      d = dat(1, b);
      @(negedge clk) in_data1 = d;
      @(posedge clk); #1;
      iv1 = '0;
      iv1[(b/COL1)*IW +: IW] = fld(b % COL1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      mm1[(b/COL1)*LW +: LW] = d;
      chk($sformatf("k4_beat%0d", b), 256'({inst1, mem_in1}), 256'({iv1, mm1}));
    end
    @(negedge clk) in_valid1 = 1'b0;
    w = 0;
    while (done1 !== 1'b1 && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    chk("k4_done", 256'({done1, busy1}), 256'({1'b1, 1'b0}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
